// File: rtl/ds1302_responder.sv
// ds1302_responder
//   Target end of the 3-wire CE/SCLK/SDA link driven by i2c_main. All three
//   link inputs are oversampled by clk through SYNC_STAGES flops. A frame is a
//   command byte {R/W, addr[4:0], R/C, marker} followed by 8 data bits, both
//   MSB first and sampled on SCLK falling edges while CE is high. Writes land
//   in a 64x8 register file at {R/C, addr}. Reads return that entry MSB first
//   on io_SDA, advancing one bit per SCLK rising edge.
//
//   Optional feature (macro DS1302_WRITE_PROTECT_EN): bit 7 of clock-bank
//   address 7 acts as a write-protect bit. While it is set, only writes to
//   that location are accepted.
//
// Ports
//   clk, reset     system clock, asynchronous active-high reset
//   i_CE, i_SCLK   chip enable and serial clock from the master
//   io_SDA         serial data; driven only during the read-data phase
//   o_wr_strobe    one-clk pulse when a write commits
//   o_wr_addr      {R/C, addr} of the last committed write
//   o_wr_data      data of the last committed write
//   o_rd_strobe    one-clk pulse when a read command is decoded
//   o_cmd_err      command marker bit was 0; sticky until the next CE rise
//   i_host_addr    backdoor read address
//   o_host_data    combinational backdoor read of the register file
module ds1302_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_CE,
  input  logic       i_SCLK,
  inout  wire        io_SDA,
  output logic       o_wr_strobe,
  output logic [5:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_strobe,
  output logic       o_cmd_err,
  input  logic [5:0] i_host_addr,
  output logic [7:0] o_host_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WR_DATA, S_RD_DATA, S_DONE, S_ERR
  } state_e;

  // Input synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] ce_sync_q, sclk_sync_q, sda_sync_q;
  logic ce_prev_q, sclk_prev_q;
  logic ce_s, sclk_s, sda_s;
  logic ce_rise, ce_fall, sclk_rise, sclk_fall;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  cmd_q, cmd_d;        // bits [6:0] of the command byte
  logic [7:0]  shift_q, shift_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic        cmd_err_q, cmd_err_d;

  logic [7:0]  mem_q [0:63];
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [7:0]  mem_wdata;

  logic [7:0]  cmd_full, data_full;
  logic [5:0]  cmd_addr;
  logic        wr_allowed;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_sync_q   <= '0;
      sclk_sync_q <= '0;
      sda_sync_q  <= '0;
      ce_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], i_CE};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SCLK};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], io_SDA};
      ce_prev_q   <= ce_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign ce_s      = ce_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign ce_rise   =  ce_s   & ~ce_prev_q;
  assign ce_fall   = ~ce_s   &  ce_prev_q;
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;

  // Byte as it stands once the bit arriving this cycle is shifted in
  assign cmd_full  = {cmd_q, sda_s};
  assign data_full = {shift_q[6:0], sda_s};
  // Address of a completed command: {R/C, addr}
  assign cmd_addr  = {cmd_q[1], cmd_q[6:2]};

`ifdef DS1302_WRITE_PROTECT_EN
  assign wr_allowed = ~mem_q[6'h07][7] | (cmd_addr == 6'h07);
`else
  assign wr_allowed = 1'b1;
`endif

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    cmd_err_d   = cmd_err_q;
    mem_we      = 1'b0;
    mem_waddr   = cmd_addr;
    mem_wdata   = data_full;

    if (ce_fall) begin
      // Abort from any state; nothing pending is committed
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ce_rise) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
            cmd_err_d = 1'b0;
          end
        end
        S_CMD: begin
          if (sclk_fall) begin
            cmd_d = cmd_full[6:0];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (!cmd_full[0]) begin
                state_d   = S_ERR;
                cmd_err_d = 1'b1;
              end else if (!cmd_full[7]) begin
                state_d = S_WR_DATA;
              end else begin
                state_d     = S_RD_DATA;
                rd_strobe_d = 1'b1;
                shift_d     = mem_q[{cmd_full[1], cmd_full[6:2]}];
                sda_oe_d    = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_WR_DATA: begin
          if (sclk_fall) begin
            shift_d = data_full;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = S_DONE;
              if (wr_allowed) begin
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = cmd_addr;
                wr_data_d   = data_full;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RD_DATA: begin
          // bit_cnt counts rising edges. The 8th rise leaves bit 0 on the line
          // until the falling edge that completes it.
          if (sclk_rise && bit_cnt_q != 4'd8) begin
            if (bit_cnt_q != 4'd7) shift_d = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (sclk_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = S_DONE;
          end
        end
        S_DONE, S_ERR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      shift_q     <= '0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // NOTE: the register file has a defined reset value, so it is built from
  // resettable flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= RESET_VALUE;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // The write above lands on the clock edge, so a backdoor read in the commit
  // cycle still returns the old contents.
  assign o_host_data = mem_q[i_host_addr];

  assign io_SDA      = sda_oe_q ? shift_q[7] : 1'bz;
  assign o_wr_strobe = wr_strobe_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_rd_strobe = rd_strobe_q;
  assign o_cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_ds1302_responder.sv
// tb_ds1302_responder
//   Bit-bangs CE/SCLK/SDA frames into ds1302_responder. Expected strobes are
//   queued when a frame is issued and a negedge monitor pops and compares
//   them. A plain array models the register file. A pullup on SDA makes a
//   released line read as 1.
module tb_ds1302_responder;

  localparam logic [7:0] RV = 8'h00;
  localparam int H = 6;            // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       ce, sclk, sda_oe, sda_val;
  wire        sda_w;
  logic [5:0] host_addr;
  logic       wr_strobe, rd_strobe, cmd_err;
  logic [5:0] wr_addr;
  logic [7:0] wr_data, host_data;

  assign sda_w = sda_oe ? sda_val : 1'bz;
  pullup (sda_w);

  ds1302_responder #(.SYNC_STAGES(2), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .i_CE(ce), .i_SCLK(sclk), .io_SDA(sda_w),
    .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_strobe(rd_strobe), .o_cmd_err(cmd_err),
    .i_host_addr(host_addr), .o_host_data(host_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] old;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  int         rd_q[$];
  logic [7:0] model [0:63];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor
  initial begin
    logic [7:0] prev_host;
    wr_exp_t    e;
    prev_host = '0;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr_strobe: got addr %0h data %0h expected no write", wr_addr, wr_data);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", {26'd0, wr_addr}, {26'd0, e.addr});
          check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
          if (host_addr == e.addr) begin
            check("backdoor_old_at_commit", {24'd0, prev_host}, {24'd0, e.old});
            check("backdoor_new_after_commit", {24'd0, host_data}, {24'd0, e.data});
          end
        end
      end
      if (rd_strobe) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd_strobe: got pulse expected none");
        end else begin
          void'(rd_q.pop_front());
        end
      end
      prev_host = host_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic wr_ok(input logic [5:0] a);
`ifdef DS1302_WRITE_PROTECT_EN
    return !model[7][7] || a == 6'h07;
`else
    return 1'b1;
`endif
  endfunction

  task automatic send_bit(input logic b);
    wait_clks(1);              // hold previous bit past the falling edge
    sda_oe = 1'b1; sda_val = b;
    wait_clks(H - 1);
    sclk = 1'b1; wait_clks(H);
    sclk = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clks(H);
    b = sda_w;
    sclk = 1'b1; wait_clks(H);
    sclk = 1'b0;
  endtask

  task automatic do_frame(input logic rw, input logic [4:0] addr, input logic rc,
                          input logic marker, input logic [7:0] wdata, input int nbits,
                          output logic [7:0] rdata);
    logic [7:0] cmd;
    logic b;
    cmd = {rw, addr, rc, marker};
    rdata = '0;
    sda_oe = 1'b0;
    wait_clks(1);
    check("sda_released_idle", {31'd0, sda_w}, 32'd1);
    ce = 1'b1; wait_clks(H);
    for (int i = 0; i < 8 && i < nbits; i++) send_bit(cmd[7-i]);
    if (nbits > 8) begin
      if (rw) begin
        wait_clks(1); sda_oe = 1'b0;
        for (int i = 0; i < 8; i++) begin
          read_bit(b);
          rdata[7-i] = b;
        end
        wait_clks(H);
        check("sda_released_after_read", {31'd0, sda_w}, 32'd1);
      end else begin
        for (int i = 8; i < nbits; i++) send_bit(wdata[15-i]);
      end
    end
    wait_clks(1); sda_oe = 1'b0;
    wait_clks(H);
    ce = 1'b0;
    wait_clks(2 * H);
  endtask

  // Issue a frame: queue the expected strobes, update the model, run it, check.
  task automatic issue(input logic rw, input logic [4:0] addr, input logic rc,
                       input logic marker, input logic [7:0] wdata, input int nbits);
    logic [5:0] a;
    logic [7:0] exp_rd, rdata;
    wr_exp_t e;
    a = {rc, addr};
    exp_rd = marker ? model[a] : 8'hFF;
    host_addr = a;
    if (marker && nbits >= 8 && rw) rd_q.push_back(1);
    if (marker && nbits >= 16 && !rw && wr_ok(a)) begin
      e.addr = a; e.data = wdata; e.old = model[a];
      wr_q.push_back(e);
      model[a] = wdata;
    end
    do_frame(rw, addr, rc, marker, wdata, nbits, rdata);
    if (rw && nbits >= 16) check("read_data", {24'd0, rdata}, {24'd0, exp_rd});
    check("cmd_err", {31'd0, cmd_err}, {31'd0, (nbits >= 8) && !marker});
    check("backdoor_after_frame", {24'd0, host_data}, {24'd0, model[a]});
  endtask

  task automatic backdoor(input string name, input logic [5:0] a, input logic [7:0] exp);
    host_addr = a;
    wait_clks(1);
    check(name, {24'd0, host_data}, {24'd0, exp});
  endtask

  initial begin
    logic rw, rc, mk;
    logic [4:0] ad;
    logic [7:0] dt;
    int nb;
    for (int i = 0; i < 64; i++) model[i] = RV;
    reset = 1'b1; ce = 1'b0; sclk = 1'b0; sda_oe = 1'b0; sda_val = 1'b0; host_addr = '0;
    wait_clks(4);
    reset = 1'b0;
    wait_clks(2);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_rd_strobe", {31'd0, rd_strobe}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_sda", {31'd0, sda_w}, 32'd1);
    backdoor("rst_mem_2a", 6'h2A, RV);

    // Basic write then read back
    issue(1'b0, 5'h0A, 1'b1, 1'b1, 8'hA5, 16);
    backdoor("bd_2a", 6'h2A, 8'hA5);
    issue(1'b1, 5'h0A, 1'b1, 1'b1, 8'h00, 16);

    // Independent banks; reading 8'h22 ends on a 0 so release is visible
    issue(1'b0, 5'h03, 1'b0, 1'b1, 8'h11, 16);
    issue(1'b0, 5'h03, 1'b1, 1'b1, 8'h22, 16);
    backdoor("bd_03", 6'h03, 8'h11);
    backdoor("bd_23", 6'h23, 8'h22);
    issue(1'b1, 5'h03, 1'b1, 1'b1, 8'h00, 16);

    // Bad marker on a read of a non-FF location: line must stay released
    issue(1'b1, 5'h0A, 1'b1, 1'b0, 8'h00, 16);
    check("cmd_err_sticky", {31'd0, cmd_err}, 32'd1);
    issue(1'b1, 5'h03, 1'b0, 1'b1, 8'h00, 16);

    // Abort after 12 bits, then a full write to the top address
    issue(1'b0, 5'h05, 1'b0, 1'b1, 8'h77, 12);
    backdoor("bd_05_unchanged", 6'h05, RV);
    issue(1'b0, 5'h1F, 1'b1, 1'b1, 8'h3C, 16);
    backdoor("bd_3f", 6'h3F, 8'h3C);

`ifdef DS1302_WRITE_PROTECT_EN
    issue(1'b0, 5'h07, 1'b0, 1'b1, 8'h80, 16);
    issue(1'b0, 5'h00, 1'b1, 1'b1, 8'h55, 16);
    backdoor("wp_blocked", 6'h20, RV);
    issue(1'b0, 5'h07, 1'b0, 1'b1, 8'h00, 16);
    issue(1'b0, 5'h00, 1'b1, 1'b1, 8'h55, 16);
    backdoor("wp_cleared", 6'h20, 8'h55);
`endif

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom_range(0, 1));
      ad = 5'($urandom_range(0, 31));
      rc = 1'($urandom_range(0, 1));
      dt = 8'($urandom_range(0, 255));
      mk = ($urandom_range(0, 7) != 0);
      nb = 16;
      if (!rw && $urandom_range(0, 5) == 0) nb = $urandom_range(1, 15);
      issue(rw, ad, rc, mk, dt, nb);
    end

    for (int i = 0; i < 64; i++) backdoor("sweep", 6'(i), model[i]);

    wait_clks(4);
    check("wr_queue_drained", wr_q.size(), 32'd0);
    check("rd_queue_drained", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ds1302_responder.md
Name: ds1302_responder

Overview:
- Synthesizable responder for the 3-wire CE/SCLK/SDA serial link driven by i2c_main; it is the other end of that link.
- Decodes the command byte and stores write data in an internal 64x8 register file (clock bank + RAM bank).
- Returns read data MSB-first on the shared SDA line.
- Used as the on-chip target in system simulation and as the FPGA loopback target for the master.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on CE/SCLK/SDA inputs (≥2).
- RESET_VALUE, 8'h00, reset contents of every register-file entry.

Ports:
- clk  in  1  system clock; sole clock domain
- reset  in  1  asynchronous, active-high reset
- i_CE  in  1  chip enable from master; transfer frame while high
- i_SCLK  in  1  serial clock from master
- io_SDA  inout  1  serial data; driven only during read-data phase, else 'z
- o_wr_strobe  out  1  one-clk pulse when a write commits
- o_wr_addr  out  6  {R/C, addr[4:0]} of last committed write
- o_wr_data  out  8  data of last committed write
- o_rd_strobe  out  1  one-clk pulse when a read command is decoded
- o_cmd_err  out  1  sticky until next CE rise: command marker bit was 0
- i_host_addr  in  6  backdoor read address
- o_host_data  out  8  combinational backdoor read of register file

Behaviour:
- Reset (async): state IDLE; all outputs 0; SDA released; register file = RESET_VALUE; shift regs/counters 0.
- i_CE, i_SCLK, io_SDA pass through SYNC_STAGES flops; edges detected one clk later.
- Master timing requirement: SCLK high and low each ≥ SYNC_STAGES+2 clk.
- Frame layout, MSB first: command byte [7]=R/W (0 write, 1 read), [6:2]=addr, [1]=R/C, [0]=marker (must be 1); then 8 data bits.
- Bits are sampled on synchronized SCLK falling edge while CE high.
- States:
  - IDLE: SDA released. CE rise -> CMD; clear bit counter and o_cmd_err.
  - CMD: shift 8 bits. After the 8th bit:
    - marker=0 -> ERR, set o_cmd_err.
    - R/W=0 -> WR_DATA.
    - R/W=1 -> RD_DATA; pulse o_rd_strobe; load shift reg from mem[{R/C,addr}]; drive bit7 on io_SDA within 1 clk.
  - WR_DATA: shift 8 bits. On the 8th falling edge: mem[{R/C,addr}] <= data; pulse o_wr_strobe the next clk; update o_wr_addr/o_wr_data; -> DONE.
  - RD_DATA: on each synchronized SCLK rising edge after the command, shift left and drive the next bit. After the falling edge that completes bit 0, release SDA -> DONE. Exactly 8 bits driven.
  - DONE / ERR: ignore SCLK; SDA released; wait for CE low -> IDLE.
- CE fall in any state: abort to IDLE within 1 clk of the synchronized edge; no write commit; SDA released immediately.
- Backdoor port never blocks a serial transfer.
- Same-clk serial write commit and backdoor read of the same address: backdoor returns the old value.
- Address 5'h1F is an ordinary location (no burst mode).
- SCLK edges while CE low are ignored.

Optional Feature:
- Macro: DS1302_WRITE_PROTECT_EN.
- Defined:
  - Bit7 of clock-bank address 7 (mem[6'b0_00111]) is the WP bit.
  - While WP=1, writes to every address except that one are discarded: no o_wr_strobe, o_wr_addr/o_wr_data unchanged, state still -> DONE.
  - A write to address 7 of the clock bank is always accepted.
- Not defined: all writes commit; bit7 of that location is ordinary storage.

Test Plan:
- Write addr=5'h0A, R/C=1, data=8'hA5 → o_wr_strobe one clk, o_wr_addr=6'h2A, o_wr_data=8'hA5; backdoor 6'h2A reads 8'hA5.
- After that write, read addr=5'h0A, R/C=1 → o_rd_strobe pulses; master o_rd_data=8'hA5; SDA is 'z before command end and after 8th bit.
- Write with R/C=0 vs R/C=1 to addr=5'h03, data 8'h11 / 8'h22 → backdoor 6'h03=8'h11, 6'h23=8'h22 (banks independent).
- Command byte with marker=0 → o_cmd_err=1, no strobe, SDA never driven, memory unchanged; next valid frame clears o_cmd_err.
- CE dropped after 12 bits of a write → no o_wr_strobe, memory unchanged; next full write to addr 5'h1F, data 8'h3C succeeds.
- With DS1302_WRITE_PROTECT_EN: write 8'h80 to clock-bank addr 7, then write 8'h55 to RAM addr 5'h00 → no strobe, backdoor 6'h20 keeps RESET_VALUE. Write 8'h00 to clock-bank addr 7, repeat the RAM write → backdoor 6'h20=8'h55.
